rotation_cmd_parser: RTL and testbench

ROTATION_CMD_PARSER -- requirements
Module: rotation_cmd_parser

---
 rtl/rotation_cmd_parser.sv | 207 ++++++++++++++++++++
 tb/tb_rotation_cmd_parser.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_cmd_parser.sv
// Parses an ASCII rotation list ("R68\n", "L30\n", ...) into direction/distance command strobes.
// Latency: the strobe appears the cycle after the terminating '\n' (or in_last byte) is accepted, if ready is high.
// Backpressure: in_ready drops while a command is pending or awaiting ready; the strobe waits for ready.
module rotation_cmd_parser #(
  parameter int unsigned MAX_DIST = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        valid,
  output logic        direction,
  output logic [15:0] distance,
  input  logic        ready,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count,
  output logic        done
);

  localparam logic [7:0]  CH_R   = 8'h52;
  localparam logic [7:0]  CH_L   = 8'h4C;
  localparam logic [7:0]  CH_LF  = 8'h0A;
  localparam logic [7:0]  CH_CR  = 8'h0D;
  localparam logic [7:0]  CH_0   = 8'h30;
  localparam logic [7:0]  CH_9   = 8'h39;
  localparam logic [15:0] MAX_D16 = 16'(MAX_DIST);
  localparam logic [20:0] MAX_D21 = 21'(MAX_DIST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGITS,
    S_SKIP,
    S_ISSUE,
    S_HOLD,
    S_WAIT_ACK,
    S_FINISHED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;         // distance being accumulated for the current line
  logic        dig_q, dig_d;         // at least one digit seen on this line
  logic        line_dir_q, line_dir_d;
  logic        last_q, last_d;       // current line was terminated by in_last
  logic        dir_q, dir_d;         // direction of the most recently issued command
  logic [15:0] dist_q, dist_d;       // distance of the most recently issued command
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] err_q, err_d;

  logic        take;
  logic        fire;
  logic        is_digit;
  logic        is_dir;
  logic        line_end;             // '\n', or '\r' that carries in_last (acts as '\r' then '\n')
  logic [20:0] acc_mul;
  logic [15:0] acc_sat;

  // Byte classification and saturating decimal accumulate
  always_comb begin
    is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    is_dir   = (in_data == CH_R) || (in_data == CH_L);
    line_end = (in_data == CH_LF) || ((in_data == CH_CR) && in_last);
    acc_mul  = ({5'd0, acc_q} * 21'd10) + {17'd0, in_data[3:0]};
    acc_sat  = (acc_mul > MAX_D21) ? MAX_D16 : acc_mul[15:0];
  end

  // Handshake qualifiers; both are forced low while reset is asserted
  always_comb begin
    in_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_DIGITS) || (state_q == S_SKIP));
    take     = in_valid && in_ready;
    fire     = rst_n && (state_q == S_ISSUE) && ready;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dig_d      = dig_q;
    line_dir_d = line_dir_q;
    last_d     = last_q;
    dir_d      = dir_q;
    dist_d     = dist_q;
    cmd_d      = cmd_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          if (is_dir) begin
            line_dir_d = (in_data == CH_R);
            acc_d      = 16'd0;
            dig_d      = 1'b0;
            last_d     = 1'b0;
            // A direction letter that ends the stream is a line with no digits
            if (in_last) begin
              err_d   = err_q + 16'd1;
              state_d = S_FINISHED;
            end else begin
              state_d = S_DIGITS;
            end
          end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
            if (in_last) state_d = S_FINISHED;
          end else begin
            err_d   = err_q + 16'd1;
            state_d = in_last ? S_FINISHED : S_SKIP;
          end
        end
      end

      S_DIGITS: begin
        if (take) begin
          if (is_digit) begin
            acc_d = acc_sat;
            dig_d = 1'b1;
            if (in_last) begin
              last_d  = 1'b1;
              state_d = S_ISSUE;
            end
          end else if (line_end) begin
            if (dig_q) begin
              last_d  = in_last;
              state_d = S_ISSUE;
            end else begin
              err_d   = err_q + 16'd1;
              state_d = in_last ? S_FINISHED : S_IDLE;
            end
          end else if (in_data == CH_CR) begin
            // Bare '\r' inside a line is tolerated (CRLF line endings)
            state_d = S_DIGITS;
          end else begin
            err_d   = err_q + 16'd1;
            state_d = in_last ? S_FINISHED : S_SKIP;
          end
        end
      end

      S_SKIP: begin
        if (take && ((in_data == CH_LF) || in_last)) begin
          state_d = in_last ? S_FINISHED : S_IDLE;
        end
      end

      S_ISSUE: begin
        if (fire) begin
          dir_d   = line_dir_q;
          dist_d  = acc_q;
          cmd_d   = cmd_q + 16'd1;
          state_d = S_HOLD;
        end
      end

      // Guarantees a gap after the strobe so the dial block can drop ready
      S_HOLD: begin
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (ready) state_d = last_q ? S_FINISHED : S_IDLE;
      end

      S_FINISHED: begin
        state_d = S_FINISHED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= 16'd0;
      dig_q      <= 1'b0;
      line_dir_q <= 1'b0;
      last_q     <= 1'b0;
      dir_q      <= 1'b0;
      dist_q     <= 16'd0;
      cmd_q      <= 16'd0;
      err_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dig_q      <= dig_d;
      line_dir_q <= line_dir_d;
      last_q     <= last_d;
      dir_q      <= dir_d;
      dist_q     <= dist_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
    end
  end

  // Command outputs: the strobe cycle shows the live line values, later cycles the held copy
  always_comb begin
    valid     = fire;
    direction = fire ? line_dir_q : dir_q;
    distance  = fire ? acc_q : dist_q;
    cmd_count = cmd_q;
    err_count = err_q;
    done      = (state_q == S_FINISHED);
  end

endmodule

// File: tb/tb_rotation_cmd_parser.sv
// Directed bench for rotation_cmd_parser: one task per scenario with hand-computed expectations.
module tb_rotation_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        valid;
  logic        direction;
  logic [15:0] distance;
  logic        ready;
  logic [15:0] cmd_count;
  logic [15:0] err_count;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [16:0] q_stb[$];
  int          dbl = 0;
  bit          prev_v = 1'b0;

  rotation_cmd_parser #(.MAX_DIST(65535)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .valid     (valid),
    .direction (direction),
    .distance  (distance),
    .ready     (ready),
    .cmd_count (cmd_count),
    .err_count (err_count),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (valid === 1'b1) q_stb.push_back({direction, distance});
    if (valid === 1'b1 && prev_v) dbl++;
    prev_v = (valid === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout byte=%02h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h52; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    cycles(2);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, direction, distance, cmd_count, err_count, done} !== 50'd0) begin
      errors++;
      $display("FAIL rst_outputs got v=%b d=%b dist=%0d cmd=%0d err=%0d done=%b required all 0",
               valid, direction, distance, cmd_count, err_count, done);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int base;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("R68\n", 1'b0);
    @(negedge clk);
    checks++;
    if ({valid, direction, distance} !== {1'b1, 1'b1, 16'd68}) begin
      errors++;
      $display("FAIL basic_latency got v=%b d=%b dist=%0d required v=1 d=1 dist=68", valid, direction, distance);
    end
    @(posedge clk); #1;
    send_str("L30\n", 1'b0);
    cycles(5);
    checks++;
    if (q_stb.size() - base != 2) begin
      errors++; $display("FAIL basic_count got %0d strobes required 2", q_stb.size() - base);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b1, 16'd68} || q_stb[base+1] !== {1'b0, 16'd30}) begin
        errors++;
        $display("FAIL basic_cmds got %h %h required 10044 0001e", q_stb[base], q_stb[base+1]);
      end
    end
    checks++;
    if (cmd_count !== 16'd2 || err_count !== 16'd0) begin
      errors++; $display("FAIL basic_counters got cmd=%0d err=%0d required cmd=2 err=0", cmd_count, err_count);
    end
  endtask

  task automatic test_backpressure;
    int base;
    int bad = 0;
    do_reset();
    ready = 1'b0;
    base = q_stb.size();
    send_str("L5\n", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || q_stb.size() != base) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles %0d strobes required 0 0", bad, q_stb.size() - base);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, direction, distance, in_ready} !== {1'b1, 1'b0, 16'd5, 1'b0}) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%b dist=%0d ir=%b required v=1 d=0 dist=5 ir=0",
               valid, direction, distance, in_ready);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL bp_single_pulse got valid=%b required 0", valid); end
    cycles(4);
    checks++;
    if (q_stb.size() - base != 1 || cmd_count !== 16'd1 || direction !== 1'b0 || distance !== 16'd5) begin
      errors++;
      $display("FAIL bp_after got strobes=%0d cmd=%0d d=%b dist=%0d required 1 1 0 5",
               q_stb.size() - base, cmd_count, direction, distance);
    end
  endtask

  task automatic test_errors;
    int base;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("X12\nR\nL7\n", 1'b0);
    cycles(5);
    checks++;
    if (err_count !== 16'd2 || cmd_count !== 16'd1) begin
      errors++; $display("FAIL err_counters got err=%0d cmd=%0d required err=2 cmd=1", err_count, cmd_count);
    end
    checks++;
    if (q_stb.size() - base != 1) begin
      errors++; $display("FAIL err_strobes got %0d required 1", q_stb.size() - base);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b0, 16'd7}) begin
        errors++; $display("FAIL err_cmd got %h required 00007", q_stb[base]);
      end
    end
  endtask

  task automatic test_overflow;
    int base;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("R99999\nR65535\nR65534\nL0\n", 1'b0);
    cycles(5);
    checks++;
    if (q_stb.size() - base != 4) begin
      errors++; $display("FAIL ovf_count got %0d required 4", q_stb.size() - base);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b1, 16'd65535}) begin
        errors++; $display("FAIL ovf_sat got %h required 1ffff", q_stb[base]);
      end
      checks++;
      if (q_stb[base+1] !== {1'b1, 16'd65535} || q_stb[base+2] !== {1'b1, 16'd65534} ||
          q_stb[base+3] !== {1'b0, 16'd0}) begin
        errors++;
        $display("FAIL ovf_edges got %h %h %h required 1ffff 1fffe 00000",
                 q_stb[base+1], q_stb[base+2], q_stb[base+3]);
      end
    end
    checks++;
    if (err_count !== 16'd0 || cmd_count !== 16'd4) begin
      errors++; $display("FAIL ovf_counters got err=%0d cmd=%0d required 0 4", err_count, cmd_count);
    end
  endtask

  task automatic test_last;
    int base;
    int bad = 0;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("R1\r\nL", 1'b0);
    ready = 1'b0;
    send_byte(8'h32, 1'b1);
    cycles(3);
    @(negedge clk);
    checks++;
    if ({done, valid, in_ready} !== 3'b000) begin
      errors++; $display("FAIL last_pending got done=%b v=%b ir=%b required 0 0 0", done, valid, in_ready);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, direction, distance} !== {1'b1, 1'b0, 16'd2}) begin
      errors++; $display("FAIL last_strobe got v=%b d=%b dist=%0d required 1 0 2", valid, direction, distance);
    end
    cycles(3);
    checks++;
    if (done !== 1'b1 || cmd_count !== 16'd2 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL last_done got done=%b cmd=%0d err=%0d required 1 2 0", done, cmd_count, err_count);
    end
    checks++;
    if (q_stb.size() - base != 2) begin
      errors++; $display("FAIL last_count got %0d required 2", q_stb.size() - base);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b1, 16'd1} || q_stb[base+1] !== {1'b0, 16'd2}) begin
        errors++; $display("FAIL last_cmds got %h %h required 10001 00002", q_stb[base], q_stb[base+1]);
      end
    end
    in_valid = 1'b1; in_data = 8'h52;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || done !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0 || cmd_count !== 16'd2) begin
      errors++; $display("FAIL last_sticky got %0d bad cycles cmd=%0d required 0 2", bad, cmd_count);
    end
  endtask

  task automatic test_reset_midline;
    int base;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("R4", 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_str("L3\n", 1'b0);
    cycles(5);
    checks++;
    if (q_stb.size() - base != 1 || cmd_count !== 16'd1) begin
      errors++; $display("FAIL midrst_count got %0d strobes cmd=%0d required 1 1", q_stb.size() - base, cmd_count);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b0, 16'd3}) begin
        errors++; $display("FAIL midrst_cmd got %h required 00003", q_stb[base]);
      end
    end
    // Reset while a command waits in ISSUE must drop it
    ready = 1'b0;
    base = q_stb.size();
    send_str("R9\n", 1'b0);
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    ready = 1'b1;
    cycles(5);
    checks++;
    if (q_stb.size() != base || cmd_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL issue_rst got %0d strobes cmd=%0d err=%0d required 0 0 0",
               q_stb.size() - base, cmd_count, err_count);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    do_reset();
    ready = 1'b1;
    base = q_stb.size();
    send_str("\n\r\nR2\n", 1'b0);
    cycles(5);
    checks++;
    if (err_count !== 16'd0 || q_stb.size() - base != 1) begin
      errors++; $display("FAIL blank_lines got err=%0d strobes=%0d required 0 1", err_count, q_stb.size() - base);
    end else begin
      checks++;
      if (q_stb[base] !== {1'b1, 16'd2}) begin
        errors++; $display("FAIL blank_cmd got %h required 10002", q_stb[base]);
      end
    end
    send_byte(8'h5A, 1'b1);
    cycles(2);
    checks++;
    if (done !== 1'b1 || err_count !== 16'd1 || cmd_count !== 16'd1 || q_stb.size() - base != 1) begin
      errors++;
      $display("FAIL bad_last got done=%b err=%0d cmd=%0d strobes=%0d required 1 1 1 1",
               done, err_count, cmd_count, q_stb.size() - base);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; ready = 1'b0;
    cycles(1);
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_overflow();
    test_last();
    test_reset_midline();
    test_back_to_back();
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL valid_consecutive got %0d required 0", dbl); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
